// File: rtl/capture_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | capture_seq_pkg: state encoding, header constants and header byte mux    |
// | for capture_frame_sequencer.                       Rev 1.0 (initial)     |
// +--------------------------------------------------------------------------+
package capture_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_HDR     = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;
    localparam logic [2:0] ST_XOR     = 3'd5;

    localparam logic [7:0] SYNC0_DEFAULT  = 8'h6E;
    localparam logic [7:0] SYNC1_DEFAULT  = 8'h6F;
    localparam int         HDR_LEN        = 7;
    localparam int         STATUS_TIMEOUT = 0;

    typedef struct packed {
        logic [7:0]  tag;
        logic [7:0]  seq;
        logic [15:0] len;
        logic [7:0]  status;
    } frame_hdr_t;

    function automatic logic [7:0] hdr_byte(
        input logic [2:0] idx,
        input logic [7:0] sync0,
        input logic [7:0] sync1,
        input frame_hdr_t hdr
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync0;
            3'd1:    b = sync1;
            3'd2:    b = hdr.tag;
            3'd3:    b = hdr.seq;
            3'd4:    b = hdr.len[15:8];
            3'd5:    b = hdr.len[7:0];
            default: b = hdr.status;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_timeout_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | capture_timeout_timer: counts enabled cycles, flags the last allowed one.|
// |                                                    Rev 1.0 (initial)     |
// +--------------------------------------------------------------------------+
module capture_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/capture_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | capture_frame_sequencer: clear FIFO, fill it from the sample stream, then|
// | stream a framed dump. Macro CAPTURE_SEQ_CHECKSUM_EN adds an XOR trailer. |
// |                                                    Rev 1.0 (initial)     |
// +--------------------------------------------------------------------------+
module capture_frame_sequencer
    import capture_seq_pkg::*;
#(
    parameter int unsigned FRAME_WORDS    = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 8000000,
    parameter logic [7:0]  SYNC0          = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1          = SYNC1_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fire,
    input  logic        abort,
    input  logic [7:0]  tag,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic [15:0] fifo_data,
    output logic        fifo_we,
    output logic        fifo_clr,
    output logic        fifo_re,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        busy,
    output logic [7:0]  frame_seq
);
    localparam int                WCNT_W        = $clog2(FRAME_WORDS + 1);
    localparam logic [WCNT_W-1:0] C_FRAME_WORDS = WCNT_W'(FRAME_WORDS);

    logic [2:0]        state_q, state_d;
    logic [7:0]        tag_q, tag_d;
    logic [7:0]        seq_q, seq_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              tmo_q, tmo_d;
    logic [2:0]        hidx_q, hidx_d;
    logic [15:0]       sent_q, sent_d;
    logic [15:0]       rdcnt_q, rdcnt_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic              rd_pend_q, rd_pend_d;
    logic              abort_pend_q, abort_pend_d;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic        w_capture, w_cnt_done, w_expire, w_tx_state, w_hs, w_abort;
    logic        w_last_payload, w_end_payload;
    logic [15:0] w_len;
    logic [7:0]  w_status;
    frame_hdr_t  w_hdr;

    assign w_capture      = (state_q == ST_CAPTURE);
    assign w_cnt_done     = (wcnt_q == C_FRAME_WORDS);
    assign w_len          = 16'(wcnt_q) << 1;
    assign w_abort        = abort | abort_pend_q;
    assign w_tx_state     = (state_q == ST_HDR) | (state_q == ST_PAYLOAD) | (state_q == ST_XOR);
    assign w_last_payload = (16'(sent_q + 16'd1) == w_len);

    always_comb begin
        w_status                 = '0;
        w_status[STATUS_TIMEOUT] = tmo_q;
    end

    assign w_hdr = '{tag: tag_q, seq: seq_q, len: w_len, status: w_status};

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timer
            capture_timeout_timer #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_timer (
                .clk     (clk),
                .rst_n   (rst_n),
                .clear_i (~w_capture),
                .enable_i(w_capture),
                .expire_o(w_expire)
            );
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    endgenerate

    // Writes stop once the word budget is met so len always matches FIFO content.
    assign fifo_clr  = (state_q == ST_ARM);
    assign fifo_we   = w_capture & s_tvalid & ~fifo_full & ~w_cnt_done;
    assign fifo_data = w_capture ? s_tdata : 16'h0000;
    assign fifo_re   = (state_q == ST_PAYLOAD) & ~hold_v_q & ~rd_pend_q & ~fifo_empty
                     & (rdcnt_q < w_len) & ~w_abort;
    assign busy      = (state_q != ST_IDLE);
    assign frame_seq = seq_q;

    always_comb begin
        tx_tvalid = 1'b0;
        tx_tdata  = 8'h00;
        case (state_q)
            ST_HDR: begin
                tx_tvalid = 1'b1;
                tx_tdata  = hdr_byte(hidx_q, SYNC0, SYNC1, w_hdr);
            end
            ST_PAYLOAD: begin
                tx_tvalid = hold_v_q;
                tx_tdata  = hold_v_q ? hold_q : 8'h00;
            end
`ifdef CAPTURE_SEQ_CHECKSUM_EN
            ST_XOR: begin
                tx_tvalid = 1'b1;
                tx_tdata  = xor_q;
            end
`endif
            default: ;
        endcase
    end

    assign w_hs = tx_tvalid & tx_tready;

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        seq_d         = seq_q;
        wcnt_d        = wcnt_q;
        tmo_d         = tmo_q;
        hidx_d        = hidx_q;
        sent_d        = sent_q;
        rdcnt_d       = rdcnt_q;
        hold_d        = hold_q;
        hold_v_d      = hold_v_q;
        rd_pend_d     = rd_pend_q;
        abort_pend_d  = abort_pend_q;
        w_end_payload = 1'b0;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
        xor_d         = xor_q;
`endif
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (fire && !abort) begin
                    state_d = ST_ARM;
                    tag_d   = tag;
                end
            end
            ST_ARM: begin
                wcnt_d  = '0;
                tmo_d   = 1'b0;
                state_d = abort ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (fifo_we) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (fifo_full || w_cnt_done || w_expire) begin
                    state_d   = ST_HDR;
                    tmo_d     = w_expire & ~fifo_full & ~w_cnt_done;
                    hidx_d    = '0;
                    sent_d    = '0;
                    rdcnt_d   = '0;
                    hold_v_d  = 1'b0;
                    rd_pend_d = 1'b0;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
                    xor_d     = 8'h00;
`endif
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    if (hidx_q == 3'(HDR_LEN - 1)) begin
                        if (w_len == 16'd0) begin
                            w_end_payload = 1'b1;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        hidx_d = hidx_q + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rd_pend_q) begin
                    hold_d    = fifo_q;
                    hold_v_d  = 1'b1;
                    rd_pend_d = 1'b0;
                end
                if (fifo_re) begin
                    rd_pend_d = 1'b1;
                    rdcnt_d   = rdcnt_q + 16'd1;
                end
                if (w_hs) begin
                    hold_v_d = 1'b0;
                    sent_d   = sent_q + 16'd1;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
                    xor_d    = xor_q ^ hold_q;
`endif
                    if (w_last_payload) begin
                        w_end_payload = 1'b1;
                    end
                end
            end
`ifdef CAPTURE_SEQ_CHECKSUM_EN
            ST_XOR: begin
                if (w_hs) begin
                    state_d = ST_IDLE;
                    seq_d   = seq_q + 8'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (w_end_payload) begin
`ifdef CAPTURE_SEQ_CHECKSUM_EN
            state_d = ST_XOR;
`else
            state_d = ST_IDLE;
            seq_d   = seq_q + 8'd1;
`endif
        end

        // A pending abort only lands on a byte boundary so the sink never sees a torn byte.
        if (w_tx_state && w_abort) begin
            seq_d = seq_q;
            if (!tx_tvalid || w_hs) begin
                state_d      = ST_IDLE;
                abort_pend_d = 1'b0;
            end else begin
                state_d      = state_q;
                abort_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            seq_q        <= '0;
            wcnt_q       <= '0;
            tmo_q        <= 1'b0;
            hidx_q       <= '0;
            sent_q       <= '0;
            rdcnt_q      <= '0;
            hold_q       <= '0;
            hold_v_q     <= 1'b0;
            rd_pend_q    <= 1'b0;
            abort_pend_q <= 1'b0;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            seq_q        <= seq_d;
            wcnt_q       <= wcnt_d;
            tmo_q        <= tmo_d;
            hidx_q       <= hidx_d;
            sent_q       <= sent_d;
            rdcnt_q      <= rdcnt_d;
            hold_q       <= hold_d;
            hold_v_q     <= hold_v_d;
            rd_pend_q    <= rd_pend_d;
            abort_pend_q <= abort_pend_d;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_capture_frame_sequencer: random-stimulus bench with FIFO/UART models. |
// |                                                    Rev 1.0 (initial)     |
// +--------------------------------------------------------------------------+
module tb_capture_frame_sequencer;
    localparam int FW = 2048;
    localparam int TO = 2500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  tag = 8'h00;
    logic [15:0] s_tdata = 16'h0000;
    logic        s_tvalid = 1'b0;
    logic [15:0] fifo_data;
    logic        fifo_we, fifo_clr, fifo_re;
    logic [7:0]  fifo_q = 8'h00;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b0;
    logic        busy;
    logic [7:0]  frame_seq;

    int          n_checks = 0;
    int          n_fail = 0;
    int          txmode = 0;
    logic [7:0]  exp_seq = 8'h00;
    logic [7:0]  fq[$];
    logic [7:0]  rxq[$];
    logic [15:0] expw[$];
    logic [15:0] preset[$];

    always #5 clk = ~clk;

    capture_frame_sequencer #(
        .FRAME_WORDS   (FW),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fire      (fire),
        .abort     (abort),
        .tag       (tag),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .fifo_data (fifo_data),
        .fifo_we   (fifo_we),
        .fifo_clr  (fifo_clr),
        .fifo_re   (fifo_re),
        .fifo_q    (fifo_q),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .busy      (busy),
        .frame_seq (frame_seq)
    );

    // FIFO: 16-bit words in (high byte first), bytes out one cycle after read.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_re && fq.size() > 0) fifo_q <= fq.pop_front();
            if (fifo_we) begin
                fq.push_back(fifo_data[15:8]);
                fq.push_back(fifo_data[7:0]);
            end
        end
        fifo_full  <= (fq.size() >= 2 * FW);
        fifo_empty <= (fq.size() == 0);
    end

    always @(posedge clk) begin
        if (tx_tvalid && tx_tready) rxq.push_back(tx_tdata);
    end

    task automatic check_val(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
        end
    endtask

    task automatic tick();
        logic       stall;
        logic [7:0] d;
        stall = rst_n && tx_tvalid && !tx_tready;
        d     = tx_tdata;
        @(negedge clk);
        if (stall) begin
            check_val("stall_tvalid", tx_tvalid, 1);
            check_val("stall_tdata", tx_tdata, d);
        end
        case (txmode)
            0: tx_tready = 1'b1;
            1: tx_tready = ~tx_tready;
            2: tx_tready = 1'($urandom_range(1));
            default: ;
        endcase
    endtask

    task automatic start_capture();
        int guard;
        rxq.delete();
        expw.delete();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        guard = 0;
        while (!fifo_clr && guard < 10) begin
            tick();
            guard++;
        end
        check_val("arm_clr", fifo_clr, 1);
        tick();
        check_val("busy_capture", busy, 1);
    endtask

    task automatic offer(input int n, input int vmode, input int dmode);
        int cnt;
        cnt = 0;
        while (cnt < n) begin
            if (vmode == 0 || $urandom_range(7) != 0) begin
                s_tvalid = 1'b1;
                s_tdata  = (dmode == 0) ? 16'(cnt) : (dmode == 1) ? 16'($urandom) : preset[cnt];
                expw.push_back(s_tdata);
                cnt++;
            end else begin
                s_tvalid = 1'b0;
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tdata  = 16'h0000;
    endtask

    task automatic check_frame(input logic [7:0] t, input logic tmo);
        logic [7:0]  ef[$];
        logic [15:0] lenv;
        logic [15:0] w;
`ifdef CAPTURE_SEQ_CHECKSUM_EN
        logic [7:0]  x;
        x = 8'h00;
`endif
        lenv = 16'(expw.size() * 2);
        ef.push_back(8'h6E);
        ef.push_back(8'h6F);
        ef.push_back(t);
        ef.push_back(exp_seq);
        ef.push_back(lenv[15:8]);
        ef.push_back(lenv[7:0]);
        ef.push_back({7'd0, tmo});
        foreach (expw[i]) begin
            w = expw[i];
            ef.push_back(w[15:8]);
            ef.push_back(w[7:0]);
`ifdef CAPTURE_SEQ_CHECKSUM_EN
            x = x ^ w[15:8] ^ w[7:0];
`endif
        end
`ifdef CAPTURE_SEQ_CHECKSUM_EN
        ef.push_back(x);
`endif
        check_val("frame_len", rxq.size(), ef.size());
        for (int i = 0; i < ef.size() && i < rxq.size(); i++)
            check_val($sformatf("frame_byte[%0d]", i), rxq[i], ef[i]);
    endtask

    task automatic run_frame(input logic [7:0] t, input int n, input int vmode,
                             input int dmode, input bit fire_hdr);
        int guard;
        tag = t;
        start_capture();
        offer(n, vmode, dmode);
        if (fire_hdr) begin
            guard = 0;
            while (!tx_tvalid && guard < 5000) begin
                tick();
                guard++;
            end
            fire = 1'b1;
            tick();
            fire = 1'b0;
        end
        guard = 0;
        while (busy && guard < 20000) begin
            tick();
            guard++;
        end
        check_val("frame_done", busy, 0);
        check_frame(t, n < FW);
        exp_seq = exp_seq + 8'd1;
        check_val("frame_seq", frame_seq, exp_seq);
        tick();
        tick();
        check_val("idle_after", busy, 0);
    endtask

    initial begin
        logic [15:0] w;
        int          guard;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_tvalid", tx_tvalid, 0);
        check_val("rst_seq", frame_seq, 0);
        check_val("rst_clr", fifo_clr, 0);
        check_val("rst_we", fifo_we, 0);
        rst_n = 1'b1;
        tick();

        txmode = 0;
        run_frame(8'h05, FW, 0, 0, 0);
        txmode = 1;
        run_frame(8'h05, FW, 0, 0, 0);
        txmode = 0;
        run_frame(8'h21, 10, 0, 1, 1);
        txmode = 2;
        run_frame(8'h7A, 0, 1, 1, 0);
        for (int k = 0; k < 2; k++)
            run_frame(8'($urandom), int'($urandom_range(1, 150)), 1, 1, 0);

        fire  = 1'b1;
        abort = 1'b1;
        tick();
        fire  = 1'b0;
        abort = 1'b0;
        check_val("fire_abort_busy", busy, 0);
        check_val("fire_abort_clr", fifo_clr, 0);

        tag = 8'h44;
        start_capture();
        s_tvalid = 1'b1;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        s_tvalid = 1'b0;
        check_val("cap_abort_busy", busy, 0);
        check_val("cap_abort_seq", frame_seq, exp_seq);

        txmode = 0;
        tag    = 8'h37;
        start_capture();
        offer(30, 1, 1);
        guard = 0;
        while (!(rxq.size() == 44 && tx_tvalid) && guard < 10000) begin
            tick();
            guard++;
        end
        txmode    = 3;
        tx_tready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        w     = expw[18];
        check_val("abort_byte37", tx_tdata, w[7:0]);
        repeat (4) tick();
        check_val("abort_hold_busy", busy, 1);
        tx_tready = 1'b1;
        tick();
        tx_tready = 1'b0;
        check_val("abort_tvalid", tx_tvalid, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_rx_cnt", rxq.size(), 45);
        check_val("abort_rx_last", rxq[44], w[7:0]);
        check_val("abort_seq", frame_seq, exp_seq);

        txmode = 0;
        tag    = 8'h66;
        start_capture();
        offer(40, 1, 1);
        guard = 0;
        while (rxq.size() < 20 && guard < 5000) begin
            tick();
            guard++;
        end
        rst_n = 1'b0;
        tick();
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_tvalid", tx_tvalid, 0);
        check_val("mid_rst_tdata", tx_tdata, 0);
        check_val("mid_rst_re", fifo_re, 0);
        check_val("mid_rst_data", fifo_data, 0);
        check_val("mid_rst_seq", frame_seq, 0);
        rst_n   = 1'b1;
        exp_seq = 8'h00;
        tick();

        preset.push_back(16'h0102);
        preset.push_back(16'h0300);
        run_frame(8'h33, 2, 0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
